// File: rtl/axi_llc_refill_r_unit.sv
// Refill R-channel unit: queues descriptors, writes refill R beats into the data ways, retires descriptors in order.
// Latency: a queued descriptor reaches the head one cycle after acceptance; refills need one IDLE cycle, then one cycle per beat.
// Backpressure: R follows the way port; a last beat is held off until the output register can take the descriptor.
//
// Ports:
//   clk_i, rst_ni                          clock, asynchronous active-low reset
//   desc_i/desc_valid_i/desc_ready_o       incoming descriptors into the in-order queue
//   desc_o/desc_valid_o/desc_ready_i       registered outgoing descriptors, acceptance order
//   r_chan_mst_i/r_chan_valid_i/_ready_o   AXI R beats
//   way_inp_o/way_inp_valid_o/_ready_i     data-way write requests, one per R beat
//   refill_err_o                           one-cycle pulse on a bad burst length or error response
//   busy_o                                 queue non-empty, refill active or output register valid

package axi_llc_refill_pkg;

  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned IndexLength;
    int unsigned BlockOffsetLength;
    int unsigned ByteOffsetLength;
  } llc_cfg_t;

  typedef struct packed {
    int unsigned AddrWidthFull;
    int unsigned DataWidthFull;
  } llc_axi_cfg_t;

  typedef enum logic [1:0] {
    EvictUnit = 2'd0,
    RefilUnit = 2'd1,
    RwUnit    = 2'd2
  } cache_unit_e;

  localparam llc_cfg_t DefaultCfg = '{
    SetAssociativity:  32'd4,
    IndexLength:       32'd4,
    BlockOffsetLength: 32'd2,
    ByteOffsetLength:  32'd3
  };

  localparam llc_axi_cfg_t DefaultAxiCfg = '{
    AddrWidthFull: 32'd32,
    DataWidthFull: 32'd64
  };

  typedef struct packed {
    logic [31:0] a_x_addr;
    logic [3:0]  way_ind;
    logic        refill;
  } llc_desc_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } llc_r_chan_t;

  typedef struct packed {
    cache_unit_e cache_unit;
    logic [3:0]  way_ind;
    logic [3:0]  line_addr;
    logic [1:0]  blk_offset;
    logic        we;
    logic [63:0] data;
    logic [7:0]  strb;
  } llc_way_inp_t;

endpackage

module axi_llc_refill_r_unit #(
  parameter axi_llc_refill_pkg::llc_cfg_t     Cfg           = axi_llc_refill_pkg::DefaultCfg,
  parameter axi_llc_refill_pkg::llc_axi_cfg_t AxiCfg        = axi_llc_refill_pkg::DefaultAxiCfg,
  parameter type                              desc_t        = axi_llc_refill_pkg::llc_desc_t,
  parameter type                              way_inp_t     = axi_llc_refill_pkg::llc_way_inp_t,
  parameter type                              r_chan_t      = axi_llc_refill_pkg::llc_r_chan_t,
  parameter int unsigned                      DescDepth     = 2,
  parameter logic                             CritWordFirst = 1'b0
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  desc_t    desc_i,
  input  logic     desc_valid_i,
  output logic     desc_ready_o,
  output desc_t    desc_o,
  output logic     desc_valid_o,
  input  logic     desc_ready_i,
  input  r_chan_t  r_chan_mst_i,
  input  logic     r_chan_valid_i,
  output logic     r_chan_ready_o,
  output way_inp_t way_inp_o,
  output logic     way_inp_valid_o,
  input  logic     way_inp_ready_i,
  output logic     refill_err_o,
  output logic     busy_o
);

  localparam int unsigned BlkW    = Cfg.BlockOffsetLength;
  localparam int unsigned ByteW   = Cfg.ByteOffsetLength;
  localparam int unsigned IdxW    = Cfg.IndexLength;
  localparam int unsigned LineLsb = ByteW + BlkW;
  localparam int unsigned PtrW    = (DescDepth > 1) ? $clog2(DescDepth) : 1;
  localparam int unsigned CntW    = $clog2(DescDepth + 1);

  localparam logic [BlkW-1:0] BeatMax = '1;

  localparam logic [0:0] Idle   = 1'b0;
  localparam logic [0:0] Refill = 1'b1;

  // ---------------------------------------------------------------------------
  // Descriptor queue (registered storage, no fall-through)
  // ---------------------------------------------------------------------------
  desc_t            mem_q [DescDepth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, head_pop, full, head_vld;
  desc_t            head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DescDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full     = (count_q == CntW'(DescDepth));
  assign head_vld = (count_q != '0);
  assign head     = mem_q[rd_ptr_q];
  // A full queue still accepts when the head retires in the same cycle.
  assign desc_ready_o = !full || head_pop;
  assign push         = desc_valid_i && desc_ready_o;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= desc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)     wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (head_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, head_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head processing
  // ---------------------------------------------------------------------------
  logic [0:0]      state_q, state_d;
  logic [BlkW-1:0] off_q, off_d;
  logic [BlkW-1:0] cnt_q, cnt_d;
  logic            out_vld_q;
  desc_t           out_q;
  logic            out_free, out_load;
  logic            beat_last, stall_last, xfer, resp_err;

  // The output register can take a new descriptor when empty or draining now.
  assign out_free = !out_vld_q || desc_ready_i;
  assign resp_err = (r_chan_mst_i.resp == 2'b10) || (r_chan_mst_i.resp == 2'b11);

  always_comb begin
    state_d         = state_q;
    off_d           = off_q;
    cnt_d           = cnt_q;
    head_pop        = 1'b0;
    out_load        = 1'b0;
    beat_last       = 1'b0;
    stall_last      = 1'b0;
    xfer            = 1'b0;
    way_inp_valid_o = 1'b0;
    r_chan_ready_o  = 1'b0;
    refill_err_o    = 1'b0;
    case (state_q)
      Idle: begin
        if (head_vld) begin
          if (!head.refill) begin
            if (out_free) begin
              out_load = 1'b1;
              head_pop = 1'b1;
            end
          end else begin
            off_d   = CritWordFirst ? head.a_x_addr[ByteW +: BlkW] : '0;
            cnt_d   = '0;
            state_d = Refill;
          end
        end
      end
      Refill: begin
        // A full line ends the refill even without last; the extra beats
        // then belong to the next refill.
        beat_last  = r_chan_mst_i.last || (cnt_q == BeatMax);
        // Never take a final beat whose descriptor cannot be retired, so
        // neither the way write nor the R handshake may happen.
        stall_last = beat_last && !out_free;
        way_inp_valid_o = r_chan_valid_i && !stall_last;
        r_chan_ready_o  = way_inp_ready_i && !stall_last;
        xfer = r_chan_valid_i && way_inp_ready_i && !stall_last;
        if (xfer) begin
          off_d = off_q + BlkW'(1);
          cnt_d = cnt_q + BlkW'(1);
          refill_err_o = (r_chan_mst_i.last && (cnt_q != BeatMax)) ||
                         (!r_chan_mst_i.last && (cnt_q == BeatMax)) ||
                         resp_err;
          if (beat_last) begin
            out_load = 1'b1;
            head_pop = 1'b1;
            state_d  = Idle;
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      off_q     <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      if (out_load) begin
        out_vld_q <= 1'b1;
        out_q     <= head;
      end else if (desc_ready_i) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign desc_o       = out_q;
  assign desc_valid_o = out_vld_q;
  assign busy_o       = head_vld || (state_q == Refill) || out_vld_q;

  // ---------------------------------------------------------------------------
  // Way write request
  // ---------------------------------------------------------------------------
  always_comb begin
    way_inp_o            = '0;
    way_inp_o.cache_unit = axi_llc_refill_pkg::RefilUnit;
    way_inp_o.way_ind    = head.way_ind;
    way_inp_o.line_addr  = head.a_x_addr[LineLsb +: IdxW];
    way_inp_o.blk_offset = off_q;
    way_inp_o.we         = 1'b1;
    way_inp_o.data       = r_chan_mst_i.data;
    way_inp_o.strb       = {(AxiCfg.DataWidthFull / 8){1'b1}};
  end

endmodule

// File: tb/tb_axi_llc_refill_r_unit.sv
module tb_axi_llc_refill_r_unit;
  import axi_llc_refill_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  llc_desc_t    d_in;
  logic         d_vld, d_rdy0, d_rdy1;
  llc_desc_t    q0, q1;
  logic         q_vld0, q_vld1, q_rdy;
  llc_r_chan_t  r_dat;
  logic         r_vld, r_rdy0, r_rdy1;
  llc_way_inp_t way0, way1;
  logic         way_vld0, way_vld1, way_rdy;
  logic         err0, err1, busy0, busy1;

  int total = 0;
  int bad   = 0;

  axi_llc_refill_r_unit #(.DescDepth(2), .CritWordFirst(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .desc_i(d_in), .desc_valid_i(d_vld), .desc_ready_o(d_rdy0),
    .desc_o(q0), .desc_valid_o(q_vld0), .desc_ready_i(q_rdy),
    .r_chan_mst_i(r_dat), .r_chan_valid_i(r_vld), .r_chan_ready_o(r_rdy0),
    .way_inp_o(way0), .way_inp_valid_o(way_vld0), .way_inp_ready_i(way_rdy),
    .refill_err_o(err0), .busy_o(busy0)
  );

  axi_llc_refill_r_unit #(.DescDepth(2), .CritWordFirst(1'b1)) dut_cwf (
    .clk_i(clk), .rst_ni(rst_n),
    .desc_i(d_in), .desc_valid_i(d_vld), .desc_ready_o(d_rdy1),
    .desc_o(q1), .desc_valid_o(q_vld1), .desc_ready_i(q_rdy),
    .r_chan_mst_i(r_dat), .r_chan_valid_i(r_vld), .r_chan_ready_o(r_rdy1),
    .way_inp_o(way1), .way_inp_valid_o(way_vld1), .way_inp_ready_i(way_rdy),
    .refill_err_o(err1), .busy_o(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_addr(input logic [22:0] tag, input logic [3:0] idx,
                                          input logic [1:0] blk);
    return {tag, idx, blk, 3'b000};
  endfunction

  function automatic llc_desc_t mk(input logic refill, input logic [3:0] way, input logic [31:0] a);
    llc_desc_t d;
    d.refill   = refill;
    d.way_ind  = way;
    d.a_x_addr = a;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one descriptor for exactly one cycle; the queue must have room.
  task automatic push(input llc_desc_t d);
    d_in  = d;
    d_vld = 1'b1;
    #1;
    chk("desc_rdy", 64'(d_rdy0), 64'd1);
    step();
    d_vld = 1'b0;
  endtask

  // One R beat that must transfer this cycle.
  task automatic do_beat(input logic [63:0] d, input logic [1:0] resp, input logic last,
                         input logic [1:0] o0, input logic [1:0] o1, input logic e,
                         input logic [3:0] line);
    r_dat.data = d;
    r_dat.resp = resp;
    r_dat.last = last;
    r_vld      = 1'b1;
    way_rdy    = 1'b1;
    #1;
    chk("way_vld", 64'(way_vld0), 64'd1);
    chk("r_rdy", 64'(r_rdy0), 64'd1);
    chk("blk_off", 64'(way0.blk_offset), 64'(o0));
    chk("blk_off_cwf", 64'(way1.blk_offset), 64'(o1));
    chk("line_addr", 64'(way0.line_addr), 64'(line));
    chk("way_data", way0.data, d);
    chk("refill_err", 64'(err0), 64'(e));
    step();
    r_vld = 1'b0;
  endtask

  llc_desc_t a1, a3, b3, c3, dd, ee, ff, gg, hh, jj, kk;

  initial begin
    rst_n   = 1'b0;
    d_in    = '0;
    d_vld   = 1'b0;
    q_rdy   = 1'b0;
    r_dat   = '0;
    r_vld   = 1'b0;
    way_rdy = 1'b0;

    a1 = mk(1'b1, 4'b0001, mk_addr(23'd1, 4'd5, 2'd2));
    a3 = mk(1'b1, 4'b0010, mk_addr(23'd2, 4'd7, 2'd0));
    b3 = mk(1'b0, 4'b0100, mk_addr(23'd3, 4'd6, 2'd0));
    c3 = mk(1'b1, 4'b1000, mk_addr(23'd4, 4'd8, 2'd0));
    dd = mk(1'b0, 4'b0001, mk_addr(23'd5, 4'd9, 2'd0));
    ee = mk(1'b1, 4'b0010, mk_addr(23'd6, 4'd10, 2'd0));
    ff = mk(1'b1, 4'b0100, mk_addr(23'd7, 4'd11, 2'd0));
    gg = mk(1'b1, 4'b1000, mk_addr(23'd8, 4'd12, 2'd0));
    hh = mk(1'b1, 4'b0001, mk_addr(23'd9, 4'd13, 2'd0));
    jj = mk(1'b1, 4'b0010, mk_addr(23'd10, 4'd14, 2'd0));
    kk = mk(1'b1, 4'b0100, mk_addr(23'd11, 4'd15, 2'd1));

    // Reset state
    step();
    chk("rst_desc_vld", 64'(q_vld0), 64'd0);
    chk("rst_r_rdy", 64'(r_rdy0), 64'd0);
    chk("rst_way_vld", 64'(way_vld0), 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_desc_o", 64'(q0), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rdy_after_rst", 64'(d_rdy0), 64'd1);
    step();

    // Single refill, line block offset 2: plain order vs critical-word-first wrap
    push(a1);
    r_dat.data = 64'hA0;
    r_dat.resp = 2'b00;
    r_dat.last = 1'b0;
    r_vld      = 1'b1;
    way_rdy    = 1'b1;
    #1;
    chk("r_rdy_idle", 64'(r_rdy0), 64'd0);
    chk("way_vld_idle", 64'(way_vld0), 64'd0);
    step();
    do_beat(64'hA0, 2'b00, 1'b0, 2'd0, 2'd2, 1'b0, 4'd5);
    do_beat(64'hA1, 2'b00, 1'b0, 2'd1, 2'd3, 1'b0, 4'd5);
    do_beat(64'hA2, 2'b00, 1'b0, 2'd2, 2'd0, 1'b0, 4'd5);
    do_beat(64'hA3, 2'b00, 1'b1, 2'd3, 2'd1, 1'b0, 4'd5);
    chk("a1_out_vld", 64'(q_vld0), 64'd1);
    chk("a1_out", 64'(q0), 64'(a1));
    chk("a1_busy", 64'(busy0), 64'd1);
    q_rdy = 1'b1;
    step();
    chk("a1_drained", 64'(q_vld0), 64'd0);
    chk("idle_busy", 64'(busy0), 64'd0);
    q_rdy = 1'b0;

    // Mixed queue, R stalled: fill, then same-cycle pop/push, in-order retire
    push(a3);
    push(b3);
    d_in  = c3;
    d_vld = 1'b1;
    #1;
    chk("desc_rdy_full", 64'(d_rdy0), 64'd0);
    step();
    chk("desc_rdy_full2", 64'(d_rdy0), 64'd0);
    chk("b_not_early", 64'(q_vld0), 64'd0);
    do_beat(64'hB0, 2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 4'd7);
    do_beat(64'hB1, 2'b00, 1'b0, 2'd1, 2'd1, 1'b0, 4'd7);
    do_beat(64'hB2, 2'b00, 1'b0, 2'd2, 2'd2, 1'b0, 4'd7);
    r_dat.data = 64'hB3;
    r_dat.last = 1'b1;
    r_vld      = 1'b1;
    #1;
    chk("a3_last_r_rdy", 64'(r_rdy0), 64'd1);
    chk("desc_rdy_popthru", 64'(d_rdy0), 64'd1);
    step();
    r_vld = 1'b0;
    d_vld = 1'b0;
    chk("order_a", 64'(q0), 64'(a3));
    step();
    chk("order_a_hold", 64'(q0), 64'(a3));
    q_rdy = 1'b1;
    step();
    chk("order_b", 64'(q0), 64'(b3));
    chk("order_b_vld", 64'(q_vld0), 64'd1);
    step();
    chk("b_drained", 64'(q_vld0), 64'd0);
    do_beat(64'hC0, 2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 4'd8);
    do_beat(64'hC1, 2'b00, 1'b0, 2'd1, 2'd1, 1'b0, 4'd8);
    do_beat(64'hC2, 2'b00, 1'b0, 2'd2, 2'd2, 1'b0, 4'd8);
    do_beat(64'hC3, 2'b00, 1'b1, 2'd3, 2'd3, 1'b0, 4'd8);
    chk("order_c", 64'(q0), 64'(c3));
    step();
    q_rdy = 1'b0;

    // Output register blocked: last beat must wait
    push(dd);
    push(ee);
    chk("d_out", 64'(q0), 64'(dd));
    chk("d_out_vld", 64'(q_vld0), 64'd1);
    step();
    do_beat(64'hE0, 2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 4'd10);
    do_beat(64'hE1, 2'b00, 1'b0, 2'd1, 2'd1, 1'b0, 4'd10);
    do_beat(64'hE2, 2'b00, 1'b0, 2'd2, 2'd2, 1'b0, 4'd10);
    r_dat.data = 64'hE3;
    r_dat.last = 1'b1;
    r_vld      = 1'b1;
    #1;
    chk("r_rdy_stall", 64'(r_rdy0), 64'd0);
    chk("way_vld_stall", 64'(way_vld0), 64'd0);
    step();
    chk("r_rdy_stall2", 64'(r_rdy0), 64'd0);
    q_rdy = 1'b1;
    #1;
    chk("r_rdy_release", 64'(r_rdy0), 64'd1);
    chk("way_vld_release", 64'(way_vld0), 64'd1);
    chk("blk_off_release", 64'(way0.blk_offset), 64'd3);
    step();
    r_vld = 1'b0;
    chk("e_out", 64'(q0), 64'(ee));
    chk("e_out_vld", 64'(q_vld0), 64'd1);
    step();
    chk("e_busy", 64'(busy0), 64'd0);

    // Early last, then an error response mid-burst
    push(ff);
    push(gg);
    do_beat(64'hF0, 2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 4'd11);
    do_beat(64'hF1, 2'b00, 1'b1, 2'd1, 2'd1, 1'b1, 4'd11);
    chk("f_out", 64'(q0), 64'(ff));
    chk("f_idle_r_rdy", 64'(r_rdy0), 64'd0);
    step();
    do_beat(64'h90, 2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 4'd12);
    do_beat(64'h91, 2'b00, 1'b0, 2'd1, 2'd1, 1'b0, 4'd12);
    do_beat(64'h92, 2'b10, 1'b0, 2'd2, 2'd2, 1'b1, 4'd12);
    do_beat(64'h93, 2'b00, 1'b1, 2'd3, 2'd3, 1'b0, 4'd12);
    chk("g_out", 64'(q0), 64'(gg));

    // Missing last on the final beat still retires the line
    push(hh);
    step();
    do_beat(64'h80, 2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 4'd13);
    do_beat(64'h81, 2'b00, 1'b0, 2'd1, 2'd1, 1'b0, 4'd13);
    do_beat(64'h82, 2'b00, 1'b0, 2'd2, 2'd2, 1'b0, 4'd13);
    do_beat(64'h83, 2'b00, 1'b0, 2'd3, 2'd3, 1'b1, 4'd13);
    chk("h_out", 64'(q0), 64'(hh));
    step();
    chk("h_busy", 64'(busy0), 64'd0);

    // Asynchronous reset in the middle of a burst
    push(jj);
    step();
    do_beat(64'h70, 2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 4'd14);
    do_beat(64'h71, 2'b00, 1'b0, 2'd1, 2'd1, 1'b0, 4'd14);
    r_dat.data = 64'h72;
    r_dat.last = 1'b0;
    r_vld      = 1'b1;
    #1;
    chk("j_beat2_vld", 64'(way_vld0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_way_vld", 64'(way_vld0), 64'd0);
    chk("arst_r_rdy", 64'(r_rdy0), 64'd0);
    chk("arst_desc_vld", 64'(q_vld0), 64'd0);
    chk("arst_busy", 64'(busy0), 64'd0);
    chk("arst_busy_cwf", 64'(busy1), 64'd0);
    chk("arst_desc_o", 64'(q0), 64'd0);
    r_vld = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rel_busy", 64'(busy0), 64'd0);
    chk("rel_desc_rdy", 64'(d_rdy0), 64'd1);
    step();
    push(kk);
    step();
    do_beat(64'h60, 2'b00, 1'b0, 2'd0, 2'd1, 1'b0, 4'd15);
    do_beat(64'h61, 2'b00, 1'b0, 2'd1, 2'd2, 1'b0, 4'd15);
    do_beat(64'h62, 2'b00, 1'b0, 2'd2, 2'd3, 1'b0, 4'd15);
    do_beat(64'h63, 2'b00, 1'b1, 2'd3, 2'd0, 1'b0, 4'd15);
    chk("k_out", 64'(q0), 64'(kk));
    chk("k_out_cwf", 64'(q1), 64'(kk));
    step();
    chk("k_busy", 64'(busy0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_llc_refill_r_unit.md
Name: axi_llc_refill_r_unit

Overview:
- Successor of the LLC refill R-channel unit. Accepts refill/pass-through descriptors into a DescDepth-entry in-order queue, so several refills can be outstanding while R beats drain.
- Writes every R beat of a line refill into the data ways. Optionally starts at the requested block (critical-word-first, wrapping offset).
- Checks burst length and RRESP, flags errors, and forwards descriptors downstream strictly in acceptance order.

Parameters:
- Cfg, llc_cfg_t'{default:'0}, static LLC configuration. Uses BlockOffsetLength, ByteOffsetLength and IndexLength.
- AxiCfg, llc_axi_cfg_t'{default:'0}, AXI parameter struct.
- desc_t, logic, LLC descriptor type. Has fields refill, way_ind, a_x_addr.
- way_inp_t, logic, data-way request type.
- r_chan_t, logic, AXI R payload type. Has fields data, resp, last.
- DescDepth, 2, descriptor queue entries. Must be ≥1; 1 gives non-overlapped operation.
- CritWordFirst, 1'b0. 1 means the refill offset starts at the address block offset and wraps; 0 means it starts at 0.

Ports:
- clk_i  in  1  clock, rising edge; the only clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- desc_i  in  desc_t  input descriptor.
- desc_valid_i  in  1  input descriptor valid.
- desc_ready_o  out  1  queue not full.
- desc_o  out  desc_t  output descriptor, registered.
- desc_valid_o  out  1  output descriptor valid.
- desc_ready_i  in  1  downstream ready.
- r_chan_mst_i  in  r_chan_t  AXI R payload.
- r_chan_valid_i  in  1  R valid.
- r_chan_ready_o  out  1  R ready.
- way_inp_o  out  way_inp_t  way write request.
- way_inp_valid_o  out  1  way request valid.
- way_inp_ready_i  in  1  way ready.
- refill_err_o  out  1  one-cycle pulse on a refill protocol/response error.
- busy_o  out  1  queue non-empty, refill active, or output register valid.

Behaviour:
- Reset (async, any time, including mid-burst):
  - Queue empty, beat counter 0, output register invalid.
  - Outputs: desc_valid_o=0, r_chan_ready_o=0, way_inp_valid_o=0, refill_err_o=0, busy_o=0, desc_o='0.
  - desc_ready_o=1 once reset deasserts.
- Queue:
  - desc_ready_o = !full. A descriptor is enqueued on desc_valid_i && desc_ready_o.
  - Enqueue and dequeue in the same cycle are allowed when full.
  - A descriptor is visible at the head no earlier than the cycle after acceptance.
- Head processing, two states:
  - IDLE: if the head is non-refill and the output register is free or being drained this cycle, move the head to the output register and pop it. No R beats are consumed.
  - IDLE: if the head has refill=1, load offset = CritWordFirst ? a_x_addr[ByteOffsetLength +: BlockOffsetLength] : 0. Clear the beat counter and go to REFILL.
  - REFILL: way_inp_valid_o = r_chan_valid_i; r_chan_ready_o = way_inp_ready_i. A beat is transferred when both are high.
  - Each transfer: offset += 1 modulo 2^BlockOffsetLength (wrap-around); beat counter += 1.
  - On the transfer with last=1: if the output register is free or draining, move the head descriptor there, pop, and return to IDLE.
  - Otherwise hold r_chan_ready_o=0 before accepting the last beat, i.e. never consume a last beat that cannot be retired.
- way_inp_o fields:
  - cache_unit = RefilUnit, way_ind = head.way_ind.
  - line_addr = head.a_x_addr[(ByteOffsetLength+BlockOffsetLength) +: IndexLength].
  - blk_offset = current offset, we=1, data = R data, strb = all ones.
- Error checks: refill_err_o pulses in the cycle of the offending beat transfer when any of these holds:
  - last=1 at beat count ≠ 2^BlockOffsetLength−1;
  - last=0 at beat count = 2^BlockOffsetLength−1 (the unit then ends the refill on this beat as if last were set and treats following beats as belonging to the next refill);
  - resp is SLVERR/DECERR on any beat.
  - Data is still written in all error cases.
- Output register: holds until desc_valid_o && desc_ready_i. Fill and drain in the same cycle are allowed (full throughput, one descriptor per cycle).
- Ordering: descriptors leave exactly in acceptance order, refill and non-refill mixed.
- R beats with no refill at the head are not accepted (r_chan_ready_o=0).

Test Plan:
- BlockOffsetLength=2, CritWordFirst=0: one refill descriptor, 4 beats with last on beat 3 → blk_offset 0,1,2,3; desc_valid_o the cycle after beat 3; refill_err_o never set.
- CritWordFirst=1, a_x_addr block offset=2: 4 beats → blk_offset 2,3,0,1 (wrap); same line_addr on all beats.
- DescDepth=2: refill A, non-refill B, refill C sent back-to-back while R beats stall → desc_ready_o=0 after the queue fills; outputs in order A,B,C; B not emitted before A.
- desc_ready_i=0 while the last beat is pending → r_chan_ready_o=0 on the last beat until the output register frees; no beat lost.
- Early last on beat 1 → refill_err_o one pulse at beat 1, descriptor retired. Then resp=SLVERR on beat 2 of the next refill → one pulse at beat 2.
- Assert rst_ni mid-burst at beat 2 → all outputs 0 asynchronously; after release, a fresh refill starts at blk_offset 0 with an empty queue.
